ex_div_ctrl: RTL and testbench
==============================

Name: ex_div_ctrl

Overview:
- Iterative multi-cycle divide/remainder sequencer for the EX stage; implements RV32M DIV, DIVU, REM and REMU.
- The single-cycle ALU does not execute these ops; this block does.
- Holds the pipeline with a stall output while a radix-2 restoring division runs.
- Returns a one-cycle result strobe to the EX result mux.

Parameters:
- WIDTH, 32, operand/result width; iteration count = WIDTH.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  EX holds a valid div/rem op (ID_EX_vld and func in DIV group).
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- opa  in  WIDTH  dividend (post-forwarding rs1).
- opb  in  WIDTH  divisor (post-forwarding rs2).
- flush  in  1  branch/kill of the EX instruction.
- stall  out  1  freeze IF/ID/EX registers.
- done  out  1  one-cycle strobe; result valid.
- result  out  WIDTH  quotient or remainder.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, done=0, result=0, counter=0, internal regs=0. Reset overrides everything, including mid-division; no done is produced for an aborted op.
- States:
  - IDLE: on start=1 and flush=0, latch op and the sign flags. For signed ops take abs(opa) and abs(opb). Load remainder=0, quotient=|opa|, counter=WIDTH-1, go to CALC.
  - CALC: each cycle, shift {rem,quo} left by 1, then trial-subtract |opb| from rem. If no borrow, keep the difference and set quo[0]=1; else restore. When counter==0 go to FIX, else decrement the counter.
  - FIX: apply signs. Quotient is negated if sign(opa)^sign(opb) for DIV. Remainder is negated if sign(opa) for REM. Then apply special cases and select quo/rem into the result reg. Go to DONE.
  - DONE: done=1 for exactly one cycle with result stable; go to IDLE. start is ignored in DONE because it is the same instruction retiring.
- stall = (state==IDLE && start && !flush) || state==CALC || state==FIX. stall=0 in DONE so the pipeline advances with the result.
- Latency: start sampled at edge E gives done high in the cycle following edge E+WIDTH+1, i.e. 34 cycles for WIDTH=32.
- Back-to-back ops: DONE→IDLE, and a new start is accepted on the edge leaving IDLE. Minimum spacing is 35 cycles.
- Special cases (RISC-V semantics, no traps):
  - Divide by zero: quotient=all ones (0xFFFFFFFF); remainder=opa.
  - Signed overflow (opa=0x80000000, opb=0xFFFFFFFF, DIV/REM): quotient=0x80000000; remainder=0.
  - Unsigned ops never sign-correct.
- Arithmetic: internal rem is WIDTH+1 bits for the trial subtract. abs() of 0x80000000 is 0x80000000 unsigned.
- Operand capture: opa, opb and op are captured only in IDLE. Later input changes (forwarding stalls) are ignored.
- flush=1 in any state other than IDLE: next state IDLE, done stays 0, result is unchanged. flush with start in IDLE means no start.
- result holds its last value between ops.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, if opb==0 or signed overflow is detected, skip CALC: IDLE→FIX→DONE, with done 2 cycles after start.
  - stall covers only those cycles.
  - Results are identical to the full path.
- Undefined: special cases also run all 32 CALC cycles; FIX forces the required values. Latency is always 34.

Test Plan:
- DIVU opa=100, opb=7 → done at cycle 34, result=14; REMU same operands → result=2; stall high cycles 0..33, low at done.
- DIV opa=-20 (0xFFFFFFEC), opb=6 → result=0xFFFFFFFD (-3); REM same operands → result=0xFFFFFFFE (-2).
- DIVU opa=5, opb=0 → result=0xFFFFFFFF; REM opa=5, opb=0 → result=5. Latency 34 without DIV_EARLY_OUT_EN, 2 with it.
- DIV opa=0x80000000, opb=0xFFFFFFFF → result=0x80000000; REM same operands → result=0.
- Abort: start DIVU, assert flush at cycle 10 → stall drops next cycle, no done pulse. Repeat with rst=0 at cycle 20 → done=0, result=0.
- Back-to-back: DIVU 1000/10 then REMU 1000/7 with start held → first done result=100, second done 35 cycles later result=6; each op produces exactly one done.

Source files
------------

// File: rtl/ex_div_ctrl.sv
// ============================================================================
// ex_div_ctrl
// ----------------------------------------------------------------------------
// Iterative divide/remainder sequencer for the EX stage. Executes the RV32M
// DIV, DIVU, REM and REMU operations with a radix-2 restoring divider that
// retires one quotient bit per clock. The pipeline is frozen through stall_o
// while the division runs, and a one-cycle done_o strobe hands the result to
// the EX result mux.
//
// Optional build macro:
//   DIV_EARLY_OUT_EN - divide-by-zero and signed overflow skip the iterative
//                      phase and go straight to sign/special-case fix-up,
//                      giving done two cycles after start instead of
//                      WIDTH+2. Results are identical either way.
//
// Ports:
//   clk_i     pipeline clock
//   rst_i     synchronous reset, active low
//   start_i   EX holds a valid div/rem op
//   op_i      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   opa_i     dividend (forwarded rs1)
//   opb_i     divisor (forwarded rs2)
//   flush_i   kill the EX instruction
//   stall_o   freeze IF/ID/EX registers
//   done_o    one-cycle strobe, result_o valid
//   result_o  quotient or remainder, held between operations
// ============================================================================
module ex_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [1:0]       state_q,    state_d;
    logic             selRem_q,   selRem_d;
    logic             negQuo_q,   negQuo_d;
    logic             negRem_q,   negRem_d;
    logic             divZero_q,  divZero_d;
    logic             ovf_q,      ovf_d;
    logic [WIDTH-1:0] opaRaw_q,   opaRaw_d;
    logic [WIDTH-1:0] divisor_q,  divisor_d;
    logic [WIDTH-1:0] rem_q,      rem_d;
    logic [WIDTH-1:0] quo_q,      quo_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic [WIDTH-1:0] result_q,   result_d;

    // Operand decode in IDLE: magnitudes and sign flags for signed ops.
    // The two's complement negation of INT_MIN is INT_MIN, which read as
    // unsigned is exactly its magnitude, so no special handling is needed.
    logic             isSigned;
    logic             signA, signB;
    logic [WIDTH-1:0] absA, absB;
    logic             divZeroIn, ovfIn;

    always_comb begin
        isSigned  = ~op_i[0];
        signA     = isSigned & opa_i[WIDTH-1];
        signB     = isSigned & opb_i[WIDTH-1];
        absA      = signA ? (~opa_i + 1'b1) : opa_i;
        absB      = signB ? (~opb_i + 1'b1) : opb_i;
        divZeroIn = (opb_i == '0);
        ovfIn     = isSigned && (opa_i == INT_MIN) && (opb_i == ALL_ONES);
    end

    // One restoring step. The partial remainder is always below the divisor,
    // so the shifted value fits WIDTH+1 bits and the top bit of the
    // WIDTH+1 bit difference is the borrow.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           borrow;

    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, divisor_q};
        borrow  = trial[WIDTH];
    end

    // Sign correction and RISC-V special-case results, applied in FIX.
    logic [WIDTH-1:0] quoFinal, remFinal, fixResult;

    always_comb begin
        quoFinal = negQuo_q ? (~quo_q + 1'b1) : quo_q;
        remFinal = negRem_q ? (~rem_q + 1'b1) : rem_q;
        if (divZero_q) begin
            quoFinal = ALL_ONES;
            remFinal = opaRaw_q;
        end else if (ovf_q) begin
            quoFinal = INT_MIN;
            remFinal = '0;
        end
        fixResult = selRem_q ? remFinal : quoFinal;
    end

    // Sequencer next-state logic. Operands are captured only on the IDLE
    // exit edge; later input changes are ignored. A flush in any busy state
    // returns to IDLE without touching the result register.
    always_comb begin
        state_d   = state_q;
        selRem_d  = selRem_q;
        negQuo_d  = negQuo_q;
        negRem_d  = negRem_q;
        divZero_d = divZero_q;
        ovf_d     = ovf_q;
        opaRaw_d  = opaRaw_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    selRem_d  = op_i[1];
                    negQuo_d  = signA ^ signB;
                    negRem_d  = signA;
                    divZero_d = divZeroIn;
                    ovf_d     = ovfIn;
                    opaRaw_d  = opa_i;
                    divisor_d = absB;
                    rem_d     = '0;
                    quo_d     = absA;
                    cnt_d     = CNT_INIT;
`ifdef DIV_EARLY_OUT_EN
                    state_d   = (divZeroIn || ovfIn) ? S_FIX : S_CALC;
`else
                    state_d   = S_CALC;
`endif
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = {quo_q[WIDTH-2:0], ~borrow};
                    rem_d = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_FIX: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fixResult;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                // start here belongs to the instruction now retiring
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any
    // division in flight and clears the result.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            selRem_q  <= 1'b0;
            negQuo_q  <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            ovf_q     <= 1'b0;
            opaRaw_q  <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            selRem_q  <= selRem_d;
            negQuo_q  <= negQuo_d;
            negRem_q  <= negRem_d;
            divZero_q <= divZero_d;
            ovf_q     <= ovf_d;
            opaRaw_q  <= opaRaw_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
        end
    end

    // stall is released in DONE so the pipeline advances with the result.
    assign stall_o  = ((state_q == S_IDLE) && start_i && !flush_i)
                    || (state_q == S_CALC) || (state_q == S_FIX);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_ex_div_ctrl.sv
// ============================================================================
// tb_ex_div_ctrl
// ----------------------------------------------------------------------------
// Directed bench for ex_div_ctrl: unsigned/signed quotient and remainder,
// divide by zero, signed overflow, flush and reset aborts, and back-to-back
// operations with start held high.
// ============================================================================
module tb_ex_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  opSel;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int vecCount  = 0;
    int missCount = 0;
    logic [31:0] lastRes = 32'h0;

`ifdef DIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = 34;
`endif
    localparam int NORMAL_LAT = 34;

    ex_div_ctrl #(.WIDTH(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .op_i     (opSel),
        .opa_i    (opa),
        .opb_i    (opb),
        .flush_i  (flush),
        .stall_o  (stall),
        .done_o   (done),
        .result_o (result)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the main sequence ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    // Single comparison point: counts every check and reports misses.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Launch one operation and follow it to its done strobe, checking the
    // latency, the stall profile, the result, the single-cycle strobe and
    // that the result holds. Operands are scrambled right after launch to
    // show they were captured.
    task automatic applyStimulus(input string name, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp, input int lat);
        int seen;
        int stallBad;
        logic [31:0] got;
        seen     = 0;
        stallBad = 0;
        got      = 32'h0;
        @(negedge clk);
        start = 1'b1;
        opSel = op;
        opa   = a;
        opb   = b;
        #2;
        if (stall !== 1'b1) stallBad++;
        for (int c = 1; c <= 80 && seen == 0; c++) begin
            @(negedge clk);
            if (stall !== ((c < lat) ? 1'b1 : 1'b0)) stallBad++;
            if (done === 1'b1) begin
                seen = c;
                got  = result;
            end
            if (c == 1) begin
                start = 1'b0;
                opa   = $urandom;
                opb   = $urandom;
                opSel = 2'($urandom);
            end
        end
        checkOutput({name, ":lat"}, 32'(seen), 32'(lat));
        checkOutput({name, ":res"}, got, exp);
        checkOutput({name, ":stall"}, 32'(stallBad), 32'd0);
        @(negedge clk);
        checkOutput({name, ":pulse"}, {31'd0, done}, 32'd0);
        checkOutput({name, ":hold"}, result, exp);
        lastRes = exp;
    endtask

    // Start a DIVU and kill it with flush at cycle 10.
    task automatic flushAbort();
        int doneSeen;
        doneSeen = 0;
        @(negedge clk);
        start = 1'b1; opSel = 2'b01; opa = 32'd100; opb = 32'd7;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
            if (c == 1) start = 1'b0;
            if (c == 11) begin
                checkOutput("flush:stall", {31'd0, stall}, 32'd0);
                flush = 1'b0;
            end
            if (c == 10) flush = 1'b1;
        end
        checkOutput("flush:nodone", 32'(doneSeen), 32'd0);
        checkOutput("flush:hold", result, lastRes);
    endtask

    // Start a DIVU and kill it with reset at cycle 20.
    task automatic resetAbort();
        int doneSeen;
        doneSeen = 0;
        @(negedge clk);
        start = 1'b1; opSel = 2'b01; opa = 32'd1000; opb = 32'd3;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done === 1'b1) doneSeen++;
            if (c == 1) start = 1'b0;
            if (c == 21) begin
                checkOutput("rstab:done", {31'd0, done}, 32'd0);
                checkOutput("rstab:res", result, 32'd0);
                checkOutput("rstab:stall", {31'd0, stall}, 32'd0);
                rst = 1'b1;
            end
            if (c == 20) rst = 1'b0;
        end
        checkOutput("rstab:nodone", 32'(doneSeen), 32'd0);
        lastRes = 32'h0;
    endtask

    // DIVU 1000/10 then REMU 1000/7 with start held across both.
    task automatic backToBack();
        int doneSeen;
        int firstAt;
        int secondAt;
        logic [31:0] firstRes;
        logic [31:0] secondRes;
        doneSeen  = 0;
        firstAt   = 0;
        secondAt  = 0;
        firstRes  = 32'h0;
        secondRes = 32'h0;
        @(negedge clk);
        start = 1'b1; opSel = 2'b01; opa = 32'd1000; opb = 32'd10;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                doneSeen++;
                if (doneSeen == 1) begin
                    firstAt  = c;
                    firstRes = result;
                    opSel = 2'b11; opa = 32'd1000; opb = 32'd7;
                end else if (doneSeen == 2) begin
                    secondAt  = c;
                    secondRes = result;
                end
            end
            if (firstAt != 0 && c == firstAt + 2) start = 1'b0;
        end
        checkOutput("b2b:lat1", 32'(firstAt), 32'd34);
        checkOutput("b2b:res1", firstRes, 32'd100);
        checkOutput("b2b:gap", 32'(secondAt - firstAt), 32'd35);
        checkOutput("b2b:res2", secondRes, 32'd6);
        checkOutput("b2b:count", 32'(doneSeen), 32'd2);
        lastRes = 32'd6;
    endtask

    // Main directed sequence.
    initial begin
        rst   = 1'b0;
        start = 1'b0;
        opSel = 2'b00;
        opa   = 32'hDEADBEEF;
        opb   = 32'h12345678;
        flush = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset:done", {31'd0, done}, 32'd0);
        checkOutput("reset:stall", {31'd0, stall}, 32'd0);
        checkOutput("reset:res", result, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus("divu100_7",  2'b01, 32'd100,       32'd7,          32'd14,        NORMAL_LAT);
        applyStimulus("remu100_7",  2'b11, 32'd100,       32'd7,          32'd2,         NORMAL_LAT);
        applyStimulus("div-20_6",   2'b00, 32'hFFFFFFEC,  32'd6,          32'hFFFFFFFD,  NORMAL_LAT);
        applyStimulus("rem-20_6",   2'b10, 32'hFFFFFFEC,  32'd6,          32'hFFFFFFFE,  NORMAL_LAT);
        applyStimulus("div7_-2",    2'b00, 32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,  NORMAL_LAT);
        applyStimulus("rem7_-2",    2'b10, 32'd7,         32'hFFFFFFFE,   32'd1,         NORMAL_LAT);
        applyStimulus("rem-7_2",    2'b10, 32'hFFFFFFF9,  32'd2,          32'hFFFFFFFF,  NORMAL_LAT);
        applyStimulus("divuMax_1",  2'b01, 32'hFFFFFFFF,  32'd1,          32'hFFFFFFFF,  NORMAL_LAT);
        applyStimulus("divuMax_3",  2'b01, 32'hFFFFFFFF,  32'd3,          32'h55555555,  NORMAL_LAT);
        applyStimulus("divu5_0",    2'b01, 32'd5,         32'd0,          32'hFFFFFFFF,  SPECIAL_LAT);
        applyStimulus("rem5_0",     2'b10, 32'd5,         32'd0,          32'd5,         SPECIAL_LAT);
        applyStimulus("rem-20_0",   2'b10, 32'hFFFFFFEC,  32'd0,          32'hFFFFFFEC,  SPECIAL_LAT);
        applyStimulus("div-5_0",    2'b00, 32'hFFFFFFFB,  32'd0,          32'hFFFFFFFF,  SPECIAL_LAT);
        applyStimulus("divOvf",     2'b00, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,  SPECIAL_LAT);
        applyStimulus("remOvf",     2'b10, 32'h80000000,  32'hFFFFFFFF,   32'd0,         SPECIAL_LAT);
        applyStimulus("divuMin_m1", 2'b01, 32'h80000000,  32'hFFFFFFFF,   32'd0,         NORMAL_LAT);

        flushAbort();
        resetAbort();
        backToBack();

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
